// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer.
package pll_seq_pkg;

   localparam int RETRY_W = 3;
   localparam int LOSS_W  = 8;

   typedef enum logic [2:0] {
      ST_PLLRST    = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } pll_state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, synchronous active-high reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   // next values of the two stages
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // two-stage register, cleared while rst is high
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock sequencer: pulses the PLL reset, waits for lock with a
// timeout and bounded retries, requires a stable lock window, then releases
// downstream reset. Optional feature macro: PLL_LOCK_LOSS_CNT_EN adds the
// lock_loss_cnt output (saturating count of lock losses while running).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PLLRST    | pll_rst driven high for PLL_RST_CYCLES cycles
// WAIT_LOCK | waiting for lock_s, retry after LOCK_TIMEOUT cycles
// STABLE    | lock_s must stay high for STABLE_CYCLES consecutive cycles
// RUN       | PLL locked, sys_rst released, ready high
// FAIL      | retries exhausted, terminal until rst
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES    = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_lock,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
   ,
   output logic [LOSS_W-1:0]  lock_loss_cnt
`endif
);

   localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

   // terminal-count values: the last cycle spent in each timed state
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

   logic lock_s;

   pll_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
   logic               pll_rst_q, pll_rst_d;
   logic               sys_rst_q, sys_rst_d;
   logic               ready_q, ready_d;
   logic               fail_q, fail_d;
`ifdef PLL_LOCK_LOSS_CNT_EN
   logic [LOSS_W-1:0]  lock_loss_cnt_q, lock_loss_cnt_d;
`endif

   sync_2ff u_sync_lock (
      .clk (clk),
      .rst (rst),
      .d   (pll_lock),
      .q   (lock_s)
   );

   // next-state, shared counter, retry/loss counters and Moore outputs from next state
   always_comb begin
      state_d     = state_q;
      retry_cnt_d = retry_cnt_q;
`ifdef PLL_LOCK_LOSS_CNT_EN
      lock_loss_cnt_d = lock_loss_cnt_q;
`endif

      case (state_q)
         ST_PLLRST: begin
            if (cnt_q == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
            end
         end
         ST_WAIT_LOCK: begin
            // a lock seen on the timeout cycle takes precedence over the retry
            if (lock_s) begin
               state_d = ST_STABLE;
            end else if (cnt_q == TO_LAST) begin
               if (retry_cnt_q == RETRY_MAX) begin
                  state_d = ST_FAIL;
               end else begin
                  state_d     = ST_PLLRST;
                  retry_cnt_d = retry_cnt_q + RETRY_W'(1);
               end
            end
         end
         ST_STABLE: begin
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
            end else if (cnt_q == STB_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!lock_s) begin
               state_d = ST_PLLRST;
`ifdef PLL_LOCK_LOSS_CNT_EN
               if (lock_loss_cnt_q != '1) begin
                  lock_loss_cnt_d = lock_loss_cnt_q + LOSS_W'(1);
               end
`endif
            end
         end
         ST_FAIL: begin
            state_d = ST_FAIL;
         end
         default: begin
            state_d = ST_PLLRST;
         end
      endcase

      // RUN and FAIL are untimed, so the counter parks at zero there
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q == ST_RUN || state_q == ST_FAIL) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      pll_rst_d = (state_d == ST_PLLRST);
      sys_rst_d = (state_d != ST_RUN);
      ready_d   = (state_d == ST_RUN);
      fail_d    = (state_d == ST_FAIL);
   end

   // state, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_PLLRST;
         cnt_q       <= '0;
         retry_cnt_q <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_q   <= 1'b1;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
`ifdef PLL_LOCK_LOSS_CNT_EN
         lock_loss_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_cnt_q <= retry_cnt_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_q   <= sys_rst_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
`ifdef PLL_LOCK_LOSS_CNT_EN
         lock_loss_cnt_q <= lock_loss_cnt_d;
`endif
      end
   end

   assign pll_rst   = pll_rst_q;
   assign sys_rst   = sys_rst_q;
   assign ready     = ready_q;
   assign fail      = fail_q;
   assign retry_cnt = retry_cnt_q;
`ifdef PLL_LOCK_LOSS_CNT_EN
   assign lock_loss_cnt = lock_loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with PLL_RST_CYCLES=4,
// LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
// Edge numbering: e=0 is the first clock edge with rst=0 (R); goto(n) leaves
// the bench 1 ns after edge R+n. An edge sampling pll_lock first at E reaches
// the FSM at E+2.
module tb_pll_lock_sequencer;

   logic       clk;
   logic       rst;
   logic       pll_lock;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [2:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_CNT_EN
   logic [7:0] lock_loss_cnt;
`endif

   int checks;
   int errors;
   int e;

   pll_lock_sequencer #(
      .PLL_RST_CYCLES (4),
      .LOCK_TIMEOUT   (32),
      .STABLE_CYCLES  (8),
      .MAX_RETRIES    (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pll_lock  (pll_lock),
      .pll_rst   (pll_rst),
      .sys_rst   (sys_rst),
      .ready     (ready),
      .fail      (fail),
      .retry_cnt (retry_cnt)
`ifdef PLL_LOCK_LOSS_CNT_EN
      ,
      .lock_loss_cnt (lock_loss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic goto(input int target);
      while (e < target) begin
         step(1);
         e++;
      end
   endtask

   // hold rst for n edges, then release; the next edge is R (e=0)
   task automatic do_reset(input int n);
      rst = 1'b1;
      step(n);
      rst = 1'b0;
      e = -1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      e        = 0;
      rst      = 1'b1;
      pll_lock = 1'b1;

      // lock tied high from reset
      step(3);
      chk("rst_pll_rst", int'(pll_rst), 1);
      chk("rst_sys_rst", int'(sys_rst), 1);
      chk("rst_ready", int'(ready), 0);
      chk("rst_fail", int'(fail), 0);
      chk("rst_retry", int'(retry_cnt), 0);
`ifdef PLL_LOCK_LOSS_CNT_EN
      chk("rst_loss", int'(lock_loss_cnt), 0);
`endif
      do_reset(0);
      goto(2);
      chk("s1_pll_rst_hi", int'(pll_rst), 1);
      goto(3);
      chk("s1_pll_rst_lo", int'(pll_rst), 0);
      chk("s1_sys_rst_hold", int'(sys_rst), 1);
      goto(11);
      chk("s1_ready_early", int'(ready), 0);
      goto(12);
      chk("s1_ready", int'(ready), 1);
      chk("s1_sys_rst", int'(sys_rst), 0);
      chk("s1_retry", int'(retry_cnt), 0);
      chk("s1_fail", int'(fail), 0);

      // lock never comes: three pulses, then FAIL at 108 cycles
      pll_lock = 1'b0;
      do_reset(2);
      goto(34);
      chk("s2_wait1_pll_rst", int'(pll_rst), 0);
      chk("s2_wait1_retry", int'(retry_cnt), 0);
      goto(35);
      chk("s2_pulse2_pll_rst", int'(pll_rst), 1);
      chk("s2_pulse2_retry", int'(retry_cnt), 1);
      goto(38);
      chk("s2_pulse2_end_hi", int'(pll_rst), 1);
      goto(39);
      chk("s2_pulse2_end_lo", int'(pll_rst), 0);
      goto(71);
      chk("s2_pulse3_pll_rst", int'(pll_rst), 1);
      chk("s2_pulse3_retry", int'(retry_cnt), 2);
      goto(106);
      chk("s2_fail_early", int'(fail), 0);
      goto(107);
      chk("s2_fail", int'(fail), 1);
      chk("s2_fail_pll_rst", int'(pll_rst), 0);
      chk("s2_fail_sys_rst", int'(sys_rst), 1);
      chk("s2_fail_retry", int'(retry_cnt), 2);
      chk("s2_fail_ready", int'(ready), 0);
      goto(127);
      chk("s2_fail_held", int'(fail), 1);
      chk("s2_fail_held_pll_rst", int'(pll_rst), 0);

      // rst pulsed in FAIL restarts everything
      rst = 1'b1;
      step(1);
      chk("s2_rst_fail", int'(fail), 0);
      chk("s2_rst_retry", int'(retry_cnt), 0);
      chk("s2_rst_pll_rst", int'(pll_rst), 1);
      chk("s2_rst_sys_rst", int'(sys_rst), 1);

      // lock glitch in STABLE at cnt=5: STABLE entered R+7, glitch reaches FSM at R+13
      do_reset(1);
      goto(4);
      pll_lock = 1'b1;
      goto(10);
      pll_lock = 1'b0;
      goto(11);
      pll_lock = 1'b1;
      goto(15);
      chk("s3_no_early_run", int'(ready), 0);
      goto(21);
      chk("s3_ready_early", int'(ready), 0);
      goto(22);
      chk("s3_ready", int'(ready), 1);
      chk("s3_sys_rst", int'(sys_rst), 0);
      chk("s3_retry", int'(retry_cnt), 0);

      // lock loss in RUN: first low sample at R+23
      pll_lock = 1'b0;
      goto(24);
      chk("s4_still_ready", int'(ready), 1);
      chk("s4_still_sys_rst", int'(sys_rst), 0);
      goto(25);
      chk("s4_loss_ready", int'(ready), 0);
      chk("s4_loss_sys_rst", int'(sys_rst), 1);
      chk("s4_loss_pll_rst", int'(pll_rst), 1);
      chk("s4_loss_retry", int'(retry_cnt), 0);
`ifdef PLL_LOCK_LOSS_CNT_EN
      chk("s4_loss_cnt1", int'(lock_loss_cnt), 1);
`endif
      goto(28);
      chk("s4_pulse_hi", int'(pll_rst), 1);
      goto(29);
      chk("s4_pulse_lo", int'(pll_rst), 0);
      // relock: first high sample at R+31, ready at R+31+10
      goto(30);
      pll_lock = 1'b1;
      goto(40);
      chk("s4_relock_early", int'(ready), 0);
      goto(41);
      chk("s4_relock_ready", int'(ready), 1);
      chk("s4_relock_retry", int'(retry_cnt), 0);

`ifdef PLL_LOCK_LOSS_CNT_EN
      for (int k = 0; k < 300; k++) begin
         pll_lock = 1'b0;
         step(1);
         pll_lock = 1'b1;
         step(16);
      end
      chk("s4_loss_sat", int'(lock_loss_cnt), 255);
      chk("s4_loss_sat_ready", int'(ready), 1);
`endif

      // rst while in RUN
      rst = 1'b1;
      step(1);
      chk("s5_rst_run_ready", int'(ready), 0);
      chk("s5_rst_run_sys_rst", int'(sys_rst), 1);
      chk("s5_rst_run_pll_rst", int'(pll_rst), 1);
`ifdef PLL_LOCK_LOSS_CNT_EN
      chk("s5_rst_loss", int'(lock_loss_cnt), 0);
`endif
      // lock reaches the FSM exactly on the timeout edge R+35
      pll_lock = 1'b0;
      do_reset(1);
      goto(32);
      pll_lock = 1'b1;
      goto(34);
      chk("s5_pre_to_pll_rst", int'(pll_rst), 0);
      goto(35);
      chk("s5_to_pll_rst", int'(pll_rst), 0);
      chk("s5_to_retry", int'(retry_cnt), 0);
      chk("s5_to_ready", int'(ready), 0);
      goto(42);
      chk("s5_ready_early", int'(ready), 0);
      goto(43);
      chk("s5_ready", int'(ready), 1);
      chk("s5_fail", int'(fail), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
